serial_adder: RTL

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a registered carry. It processes one bit per clock, LSB first, and supports add-with-carry-in and two's-complement subtract. A start/busy/done handshake lets it sit behind a controller that trades latency for area, replacing wide combinational adders in the arithmetic datapath.

---
 rtl/serial_adder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract using one full-adder cell and a registered carry.
// Latency: WIDTH cycles from the accepting edge to done; one op per WIDTH+2 cycles.
// Backpressure: none queued; start_in is only honoured in IDLE and ignored while busy/done.
//
// Ports:
//   clk_in    clock, all state updates on the rising edge
//   rst_in    synchronous active-high reset, aborts any operation in flight
//   start_in  request a new operation (sampled in IDLE only)
//   sub_in    0 = a_in + b_in + c_in, 1 = a_in - b_in (sampled with start_in)
//   a_in/b_in operands (sampled with start_in)
//   c_in      carry-in for add (ignored when subtracting)
//   busy      high while bits are still being processed
//   done      one-cycle pulse when sum/carry/overflow are updated
//   sum       registered result, held until the next done
//   carry     carry out of the MSB (subtract: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//
// WIDTH is intended for 2..64.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    // The single full-adder cell, always looking at the current LSBs.
    logic fa_s;
    logic fa_co;
    logic last_bit;

    assign fa_s     = opa_q[0] ^ opb_q[0] ^ cy_q;
    assign fa_co    = (opa_q[0] & opb_q[0]) | (opa_q[0] & cy_q) | (opb_q[0] & cy_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register and all datapath/output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_in) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start_in) begin
                    // Subtract is A + ~B + 1; c_in only matters for add.
                    opa_d = a_in;
                    opb_d = sub_in ? ~b_in : b_in;
                    cy_d  = sub_in ? 1'b1 : c_in;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                cy_d  = fa_co;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // busy rises one edge after acceptance and drops as DONE is entered.
                busy_d = !last_bit;
                if (last_bit) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_co;
                    // cy_q here is the carry into the MSB.
                    ovf_d   = cy_q ^ fa_co;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule
